// File: rtl/fifo_reader_pkg.sv
// Shared types for the FIFO stream reader: FSM state encoding and occupancy width.
package fifo_reader_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry output buffer that absorbs the FIFO's read latency; entry 0 is the head.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic [WIDTH-1:0] head
);

    logic [1:0][WIDTH-1:0] entry_q, entry_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic [OCC_W-1:0]      wr_pos;
    logic                  accept;

    always_comb begin
        // The new word lands behind whatever survives this cycle's pop.
        wr_pos = occ_q - OCC_W'(pop);
        accept = wr && !clr && (wr_pos < OCC_W'(2));

        entry_d = entry_q;
        if (pop) begin
            entry_d[0] = entry_q[1];
        end
        if (accept) begin
            entry_d[wr_pos[0]] = wr_data;
        end

        if (clr) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(accept) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q   <= '0;
            entry_q <= '0;
        end else begin
            occ_q   <= occ_d;
            entry_q <= entry_d;
        end
    end

    assign occ  = occ_q;
    assign head = entry_q[0];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a generic FIFO onto a valid/ready stream with a per-burst m_last marker.
// Define FIFO_READER_CNT_EN to add the word_cnt accepted-word counter output.
module fifo_stream_reader
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [15:0]      word_cnt
`endif
);

    localparam logic [7:0] LAST_IDX = 8'(BURST - 1);

    state_e           state_q, state_d;
    logic             inflight_q, inflight_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [OCC_W-1:0] occ;
    logic             pop;
    logic [2:0]       used;

    fifo_reader_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .wr      (inflight_q),
        .wr_data (fifo_dout),
        .pop     (pop),
        .occ     (occ),
        .head    (m_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                IDLE:    if (en) state_d = RUN;
                RUN:     if (!en && !busy) state_d = IDLE;
                FLUSH:   state_d = en ? RUN : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        m_valid = (occ != '0);
        pop     = m_valid && m_ready;
        busy    = m_valid || inflight_q;
        m_last  = m_valid && (cnt_q == LAST_IDX);
        // Reserve a slot for every word already fetched, net of the one leaving now.
        used       = 3'(occ) + 3'(inflight_q) - 3'(pop);
        fifo_rd_en = (state_q == RUN) && en && !fifo_empty && (used < 3'd2);
    end

    always_comb begin
        inflight_d = fifo_rd_en;
        cnt_d      = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (pop) begin
            cnt_d = (cnt_q == LAST_IDX) ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef FIFO_READER_CNT_EN
    logic [15:0] wcnt_q, wcnt_d;

    always_comb begin
        wcnt_d = wcnt_q;
        if (flush) begin
            wcnt_d = '0;
        end else if (pop) begin
            wcnt_d = wcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign word_cnt = wcnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: directed table, corner sequences, random vs. queue model.
module tb_fifo_stream_reader;

    localparam int WIDTH   = 8;
    localparam int BURST   = 4;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_FLUSH = 2;

    logic             clk = 1'b0;
    logic             rst_n, en, flush, fifo_empty, m_ready;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_rd_en, m_valid, m_last, busy;
    logic [WIDTH-1:0] m_data;
`ifdef FIFO_READER_CNT_EN
    logic [15:0]      word_cnt;
`endif

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .WIDTH (WIDTH),
        .BURST (BURST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .busy       (busy)
`ifdef FIFO_READER_CNT_EN
        ,
        .word_cnt   (word_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Environment FIFO contents and the reference model: words owned by the reader in fetch order.
    logic [7:0] fifo_q[$];
    logic [7:0] owned[$];
    logic [7:0] got_q[$];
    int         m_st = S_IDLE;
    int         m_cnt = 0;
    int         m_wcnt = 0;
    bit         m_infl = 1'b0;

    bit         act_rd, act_valid, act_last, act_busy;
    logic [7:0] act_data;
    int         rd_pulses = 0;
    int         rd_empty_viol = 0;

    typedef struct {
        bit         push;
        logic [7:0] pdata;
        bit         rd;
        bit         valid;
        logic [7:0] data;
        bit         last;
        bit         busy;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit e, input bit f, input bit rdy, input bit chk);
        bit         exp_valid, exp_last, exp_pop, exp_rd, exp_busy;
        logic [7:0] exp_data;
        logic [7:0] w;
        w          = 8'h00;
        rst_n      = r;
        en         = e;
        flush      = f;
        m_ready    = rdy;
        fifo_empty = (fifo_q.size() == 0);
        #1;
        exp_valid = (owned.size() - int'(m_infl)) > 0;
        exp_data  = exp_valid ? owned[0] : 8'h00;
        exp_last  = exp_valid && (m_cnt == BURST - 1);
        exp_pop   = exp_valid && rdy;
        exp_busy  = owned.size() > 0;
        exp_rd    = (m_st == S_RUN) && e && (fifo_q.size() != 0) &&
                    ((owned.size() - int'(exp_pop)) < 2);

        act_rd    = (fifo_rd_en === 1'b1);
        act_valid = (m_valid === 1'b1);
        act_last  = (m_last === 1'b1);
        act_busy  = (busy === 1'b1);
        act_data  = m_data;
        if (act_rd) begin
            rd_pulses++;
            if (fifo_empty) rd_empty_viol++;
        end
        if (act_valid && rdy) got_q.push_back(m_data);

        if (chk) begin
            check("rd_en", 32'(act_rd), 32'(exp_rd));
            check("m_valid", 32'(act_valid), 32'(exp_valid));
            check("m_last", 32'(act_last), 32'(exp_last));
            check("busy", 32'(act_busy), 32'(exp_busy));
            if (exp_valid) check("m_data", 32'(m_data), 32'(exp_data));
`ifdef FIFO_READER_CNT_EN
            check("word_cnt", 32'(word_cnt), 32'(m_wcnt));
`endif
        end

        @(posedge clk);
        #1;
        if (act_rd && fifo_q.size() > 0) begin
            w         = fifo_q.pop_front();
            fifo_dout = w;
        end
        if (!r) begin
            owned.delete();
            m_infl = 1'b0;
            m_st   = S_IDLE;
            m_cnt  = 0;
            m_wcnt = 0;
        end else begin
            if (f) begin
                owned.delete();
                m_cnt  = 0;
                m_wcnt = 0;
            end else if (exp_pop) begin
                void'(owned.pop_front());
                m_cnt  = (m_cnt == BURST - 1) ? 0 : m_cnt + 1;
                m_wcnt = (m_wcnt + 1) % 65536;
            end
            if (f)                  m_st = S_FLUSH;
            else if (m_st == S_IDLE) m_st = e ? S_RUN : S_IDLE;
            else if (m_st == S_RUN)  m_st = (!e && !exp_busy) ? S_IDLE : S_RUN;
            else                     m_st = e ? S_RUN : S_IDLE;
            if (exp_rd && act_rd) owned.push_back(w);
            m_infl = exp_rd;
        end
    endtask

    initial begin
        bit found;
        rst_n      = 1'b0;
        en         = 1'b0;
        flush      = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = 8'h00;

        vecs[0] = '{1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'hBB, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'hCC, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'hDD, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hDD, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        // Reset and reset values.
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_m_data", 32'(act_data), 32'h0);

        // Basic drain, cycle-exact table.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].push) fifo_q.push_back(vecs[i].pdata);
            cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            check($sformatf("vec%0d_rd", i), 32'(act_rd), 32'(vecs[i].rd));
            check($sformatf("vec%0d_valid", i), 32'(act_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_last", i), 32'(act_last), 32'(vecs[i].last));
            check($sformatf("vec%0d_busy", i), 32'(act_busy), 32'(vecs[i].busy));
            if (vecs[i].valid) check($sformatf("vec%0d_data", i), 32'(act_data), 32'(vecs[i].data));
        end

        // Back-pressure: only two fetches, head held stable, then lossless release.
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        fifo_q.push_back(8'h44);
        rd_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            if (act_valid) check("bp_hold", 32'(act_data), 32'h11);
        end
        check("bp_rd_pulses", 32'(rd_pulses), 32'd2);
        got_q.delete();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("bp_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check($sformatf("bp_word%0d", i), 32'(got_q[i]), 32'(8'h11 * (i + 1)));

        // Empty boundary: one word yields exactly one read, never against empty.
        for (int k = 0; k < 2; k++) begin
            fifo_q.push_back(8'h5A + 8'(k));
            rd_pulses     = 0;
            rd_empty_viol = 0;
            for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            check("empty_rd_pulses", 32'(rd_pulses), 32'd1);
            check("empty_rd_viol", 32'(rd_empty_viol), 32'd0);
        end

        // Flush with BB buffered and CC in flight; burst counter sits at 2 beforehand.
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        fifo_q.push_back(8'hCC);
        fifo_q.push_back(8'hDD);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("flush_setup_data", 32'(act_data), 32'hBB);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("flush_valid_drop", 32'(act_valid), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            if (act_valid) begin
                found = 1'b1;
                check("flush_next_data", 32'(act_data), 32'hDD);
                check("flush_next_last", 32'(act_last), 32'd0);
            end
        end
        check("flush_dd_seen", 32'(found), 32'd1);
        repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        // Reset during a transfer.
        fifo_q.push_back(8'h71);
        fifo_q.push_back(8'h72);
        fifo_q.push_back(8'h73);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("rst_rd", 32'(act_rd), 32'd0);
        check("rst_valid", 32'(act_valid), 32'd0);
        check("rst_data", 32'(act_data), 32'h0);
        check("rst_last", 32'(act_last), 32'd0);
        check("rst_busy", 32'(act_busy), 32'd0);
        repeat (8) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

`ifdef FIFO_READER_CNT_EN
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) fifo_q.push_back(8'(8'h90 + i));
        repeat (12) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("cnt_after5", 32'(word_cnt), 32'd5);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("cnt_after_flush", 32'(word_cnt), 32'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) fifo_q.push_back(8'($urandom));
            cycle(1'b1, $urandom_range(0, 7) != 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 2) != 0, 1'b1);
        end
        repeat (20) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain engine for the team's `generic_fifobuffer`. It issues `rd_en` to the FIFO, absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, and presents the words on a valid/ready stream with a per-burst `m_last` marker. It sits between the FIFO's read port and any downstream consumer, so consumers never see FIFO read timing.

## Interface
- `WIDTH`, 8, data word width; matches the FIFO's `WIDTH`.
- `BURST`, 4, words per burst; `m_last` marks the final word of each burst; legal range 1..255.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `en`  in  1  permits new FIFO reads; words already fetched are still delivered when low.
- `flush`  in  1  single-cycle pulse; discards buffered and in-flight words and restarts the burst count.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_dout`  in  WIDTH  FIFO read data; valid one cycle after an accepted `rd_en`.
- `fifo_rd_en`  out  1  FIFO read strobe.
- `m_valid`  out  1  output word valid.
- `m_data`  out  WIDTH  output word.
- `m_last`  out  1  final word of the current burst; qualified by `m_valid`.
- `m_ready`  in  1  downstream accept.
- `busy`  out  1  high whenever any word is buffered or in flight.

## Operation
- FSM states:
  - IDLE: `en`=0 and nothing buffered.
  - RUN: reads are permitted.
  - FLUSH: lasts exactly one cycle; no reads.
- FSM transitions:
  - IDLE→RUN when `en`=1.
  - RUN→IDLE when `en`=0 and `busy`=0.
  - Any state→FLUSH on `flush`=1.
  - FLUSH→RUN if `en`=1, otherwise FLUSH→IDLE.
- Pop condition: a word is popped when `m_valid && m_ready`.
- Occupancy: `occ` ranges 0..2. `inflight` is a register equal to the previous cycle's `fifo_rd_en`.
- Read issue: `fifo_rd_en` = state==RUN && `en` && !`fifo_empty` && (`occ` + `inflight` − pop) < 2. The block never asserts `fifo_rd_en` while `fifo_empty`=1.
- Capture: when `inflight`=1, `fifo_dout` is written into the buffer tail. Capture and pop may occur in the same cycle.
- Output: `m_data` is the buffer head, and `m_valid` = (`occ` > 0).
- Burst counter: ranges 0..BURST−1 and increments on each pop, wrapping to 0 after the pop where it equals BURST−1.
- Last marker: `m_last` = `m_valid` && (counter == BURST−1). With BURST=1, `m_last` is high on every word.
- Flush handling: `flush` clears `occ` and the burst counter. A word captured during the flush cycle (from `inflight`) is dropped. During FLUSH, `fifo_rd_en`=0.
- Priority: flush > capture/pop. Reset overrides everything.

## Timing
- Reset values (`rst_n`=0 at a clock edge): `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, state IDLE, `occ`=0, counter 0, `inflight`=0.
- Latency: a word appears on `m_data` with `m_valid`=1 two cycles after the `fifo_rd_en` edge: one cycle of FIFO latency plus one cycle of capture.
- Throughput: with `m_ready` held at 1 and the FIFO non-empty, the block sustains one word per cycle.
- Valid/ready rule: once asserted, `m_valid` and `m_data` hold stable until the word is accepted. The only exceptions are `flush` and reset.
- Back-pressure: with `m_ready`=0, at most 2 words are fetched and `fifo_rd_en` stays low after that.
- Reset or `flush` while a read is in flight: the returning word is discarded, and the FIFO still treats it as consumed.

## Configuration
- `FIFO_READER_CNT_EN` defined: adds output `word_cnt [15:0]`, which counts accepted output words. It wraps at 65535→0 and is cleared by reset and by `flush`.
- Without the macro: the port and its counter do not exist, and behaviour is otherwise identical.

## Structure
- Shared package `fifo_reader_pkg`: state enum (IDLE, RUN, FLUSH) and the `OCC_W`=2 constant.
- One sub-module, `fifo_reader_skid`: the 2-entry buffer with `occ`, capture/pop, head output and clear. The top level holds the FSM, read issue, burst counter and the optional count.

## Test plan
- Basic drain: reset, then `en`=1. Write AA,BB,CC,DD into the FIFO with `m_ready`=1 → outputs are AA,BB,CC,DD on consecutive cycles; `m_last` is high on DD (BURST=4); `busy` falls after DD.
- Back-pressure: hold `m_ready`=0 with 4 words queued → exactly 2 `fifo_rd_en` pulses occur, and `m_data`=AA stays stable. Release `m_ready` → the remaining words arrive in order with no loss or duplication.
- Empty boundary: a single word in the FIFO → exactly one `fifo_rd_en` pulse, and it never asserts while `fifo_empty`=1.
- Flush mid-stream: pulse `flush` while BB is buffered and CC is in flight → `m_valid`=0 the next cycle and CC is dropped. The next word delivered is DD, with the burst counter restarted so `m_last` does not fire on DD.
- Reset mid-operation: `rst_n`=0 for one edge during a transfer → all outputs return to their reset values, with no spurious `m_valid`.
- `FIFO_READER_CNT_EN`: after 5 accepted words, `word_cnt`=5; after `flush`, `word_cnt`=0.
